// File: rtl/store_aligner.sv
// Store aligner: turns a byte/half/word store into one or two lane-aligned bus beats.
// Build option: define STORE_ALIGNER_SPLIT_EN to split misaligned stores into two beats.
module store_aligner (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_wrbits,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef STORE_ALIGNER_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, FIN} state_t;

    state_t      state_q;
    logic [31:0] mem_addr_q, mem_wrdata_q;
    logic [3:0]  mem_wrbits_q;
    logic        mem_req_q, busy_q, done_q, err_q;
    logic [31:0] b2_addr_q, b2_data_q;
    logic [3:0]  b2_bits_q;
    logic        two_q;

    logic [2:0]  f3;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic        bad_type;
    logic [63:0] data_sh;
    logic [7:0]  bits_sh;
    logic        misal;
    logic [29:0] word_d;

    // Shifting into a double-width vector yields both beats at once:
    // the low half is beat 1, the high half is what spills into the next word.
    always_comb begin
        f3       = ir[14:12];
        off      = addr[1:0];
        bad_type = 1'b0;
        case (f3)
            3'b000:  mask = 4'b0001;
            3'b001:  mask = 4'b0011;
            3'b010:  mask = 4'b1111;
            default: begin
                mask     = 4'b0000;
                bad_type = 1'b1;
            end
        endcase
        data_sh = {32'h0, data} << {off, 3'b000};
        bits_sh = {4'h0, mask} << off;
        misal   = |bits_sh[7:4];
        word_d  = addr[31:2];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            mem_wrbits_q <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            b2_addr_q    <= '0;
            b2_data_q    <= '0;
            b2_bits_q    <= '0;
            two_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (bad_type || (misal && !SPLIT_EN)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= REQ1;
                            mem_req_q    <= 1'b1;
                            mem_addr_q   <= {word_d, 2'b00};
                            mem_wrdata_q <= data_sh[31:0];
                            mem_wrbits_q <= bits_sh[3:0];
                            b2_addr_q    <= {word_d + 30'd1, 2'b00};
                            b2_data_q    <= data_sh[63:32];
                            b2_bits_q    <= bits_sh[7:4];
                            two_q        <= misal;
                        end
                    end
                end
                REQ1: begin
                    if (mem_ack) begin
                        if (two_q) begin
                            state_q      <= REQ2;
                            mem_addr_q   <= b2_addr_q;
                            mem_wrdata_q <= b2_data_q;
                            mem_wrbits_q <= b2_bits_q;
                        end else begin
                            state_q      <= FIN;
                            mem_req_q    <= 1'b0;
                            mem_wrdata_q <= '0;
                            mem_wrbits_q <= '0;
                            done_q       <= 1'b1;
                        end
                    end
                end
                REQ2: begin
                    if (mem_ack) begin
                        state_q      <= FIN;
                        mem_req_q    <= 1'b0;
                        mem_wrdata_q <= '0;
                        mem_wrbits_q <= '0;
                        done_q       <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign mem_wrbits = mem_wrbits_q;
    assign mem_req    = mem_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Directed table-driven bench for store_aligner; expectations follow the active build option.
module tb_store_aligner;

    logic        clock = 1'b0;
    logic        reset, start, mem_ack;
    logic [31:0] ir, addr, data;
    logic [31:0] mem_addr, mem_wrdata;
    logic [3:0]  mem_wrbits;
    logic        mem_req, busy, done, err;

    int checks   = 0;
    int failures = 0;

    store_aligner dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .addr(addr), .data(data),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wrbits(mem_wrbits),
        .mem_req(mem_req), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] addr, data;
        int          dly;      // cycles mem_ack is withheld per beat
        int          nb;       // expected bus beats
        logic [31:0] a1, d1;
        logic [3:0]  w1;
        logic [31:0] a2, d2;
        logic [3:0]  w2;
        logic        err;
        int          lat;      // edges from the start-sampling edge to the one that raises done
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string n, logic [2:0] f, logic [31:0] a, logic [31:0] d, int dl, int nb,
                                logic [31:0] a1, logic [31:0] d1, logic [3:0] w1,
                                logic [31:0] a2, logic [31:0] d2, logic [3:0] w2, logic e, int l);
        vec_t v;
        v.name = n; v.f3 = f; v.addr = a; v.data = d; v.dly = dl; v.nb = nb;
        v.a1 = a1; v.d1 = d1; v.w1 = w1; v.a2 = a2; v.d2 = d2; v.w2 = w2; v.err = e; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        chk({nm, ".req"},    {31'h0, mem_req}, 32'h1);
        chk({nm, ".addr"},   mem_addr, a);
        chk({nm, ".wrdata"}, mem_wrdata, d);
        chk({nm, ".wrbits"}, {28'h0, mem_wrbits}, {28'h0, w});
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".req"},    {31'h0, mem_req}, 32'h0);
        chk({nm, ".addr"},   mem_addr, 32'h0);
        chk({nm, ".wrdata"}, mem_wrdata, 32'h0);
        chk({nm, ".wrbits"}, {28'h0, mem_wrbits}, 32'h0);
        chk({nm, ".busy"},   {31'h0, busy}, 32'h0);
        chk({nm, ".done"},   {31'h0, done}, 32'h0);
        chk({nm, ".err"},    {31'h0, err}, 32'h0);
    endtask

    function automatic logic [31:0] mk_ir(logic [2:0] f);
        return 32'h0000_0023 | ({29'h0, f} << 12);
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clock);
        chk({v.name, ".idle"}, {31'h0, busy}, 32'h0);
        start = 1'b1; ir = mk_ir(v.f3); addr = v.addr; data = v.data; mem_ack = 1'b0;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        for (int b = 0; b < v.nb; b++) begin
            for (int k = 0; k < v.dly; k++) begin
                if (b == 0) chk_beat({v.name, ".hold1"}, v.a1, v.d1, v.w1);
                else        chk_beat({v.name, ".hold2"}, v.a2, v.d2, v.w2);
                @(negedge clock);
                lat++;
            end
            if (b == 0) chk_beat({v.name, ".beat1"}, v.a1, v.d1, v.w1);
            else        chk_beat({v.name, ".beat2"}, v.a2, v.d2, v.w2);
            mem_ack = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            lat++;
        end
        chk({v.name, ".done"},    {31'h0, done}, 32'h1);
        chk({v.name, ".err"},     {31'h0, err}, {31'h0, v.err});
        chk({v.name, ".finreq"},  {31'h0, mem_req}, 32'h0);
        chk({v.name, ".finbits"}, {28'h0, mem_wrbits}, 32'h0);
        chk({v.name, ".findata"}, mem_wrdata, 32'h0);
        chk({v.name, ".latency"}, lat, v.lat);
        @(negedge clock);
        chk({v.name, ".done1"},   {31'h0, done}, 32'h0);
        chk({v.name, ".busy0"},   {31'h0, busy}, 32'h0);
    endtask

    initial begin
        vecs[0] = mk("sb_off2", 3'b000, 32'h0000_1002, 32'h0000_00A5, 0, 1,
                     32'h0000_1000, 32'h00A5_0000, 4'b0100, 32'h0, 32'h0, 4'b0, 1'b0, 2);
        vecs[1] = mk("sh_dly3", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 3, 1,
                     32'h0000_2000, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0, 4'b0, 1'b0, 5);
        vecs[2] = mk("sw_al", 3'b010, 32'h0000_3000, 32'h1122_3344, 1, 1,
                     32'h0000_3000, 32'h1122_3344, 4'b1111, 32'h0, 32'h0, 4'b0, 1'b0, 3);
        vecs[3] = mk("sb_off3", 3'b000, 32'h0000_4003, 32'h1234_5678, 0, 1,
                     32'h0000_4000, 32'h7800_0000, 4'b1000, 32'h0, 32'h0, 4'b0, 1'b0, 2);
        vecs[4] = mk("sh_off0", 3'b001, 32'h0000_5000, 32'hCAFE_F00D, 0, 1,
                     32'h0000_5000, 32'hCAFE_F00D, 4'b0011, 32'h0, 32'h0, 4'b0, 1'b0, 2);
        vecs[5] = mk("sh_off1", 3'b001, 32'h0000_5001, 32'h0000_BEEF, 0, 1,
                     32'h0000_5000, 32'h00BE_EF00, 4'b0110, 32'h0, 32'h0, 4'b0, 1'b0, 2);
`ifdef STORE_ALIGNER_SPLIT_EN
        vecs[6] = mk("sw_mis", 3'b010, 32'h0000_3001, 32'h1122_3344, 0, 2,
                     32'h0000_3000, 32'h2233_4400, 4'b1110, 32'h0000_3004, 32'h0000_0011, 4'b0001, 1'b0, 3);
        vecs[8] = mk("sh_wrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1, 2,
                     32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00BE, 4'b0001, 1'b0, 5);
`else
        vecs[6] = mk("sw_mis", 3'b010, 32'h0000_3001, 32'h1122_3344, 0, 0,
                     32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 1'b1, 1);
        vecs[8] = mk("sh_wrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 0,
                     32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 1'b1, 1);
`endif
        vecs[7] = mk("type011", 3'b011, 32'h0000_3001, 32'h1122_3344, 0, 0,
                     32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 1'b1, 1);
        vecs[9] = mk("type111", 3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0,
                     32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 1'b1, 1);

        reset = 1'b0; start = 1'b1; mem_ack = 1'b1; ir = mk_ir(3'b010); addr = 32'h10; data = 32'h5;
        @(negedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        start = 1'b0; mem_ack = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // mem_ack while idle must not start anything
        @(negedge clock);
        mem_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("idle_ack.req",  {31'h0, mem_req}, 32'h0);
        chk("idle_ack.busy", {31'h0, busy}, 32'h0);
        chk("idle_ack.done", {31'h0, done}, 32'h0);
        mem_ack = 1'b0;

        // start held high across two back-to-back aligned SW stores
        @(negedge clock);
        start = 1'b1; mem_ack = 1'b1; ir = mk_ir(3'b010); addr = 32'h0000_6000; data = 32'h0000_0001;
        @(negedge clock);
        chk_beat("b2b.first", 32'h0000_6000, 32'h0000_0001, 4'b1111);
        @(negedge clock);
        chk("b2b.done1",  {31'h0, done}, 32'h1);
        chk("b2b.finreq", {31'h0, mem_req}, 32'h0);
        @(negedge clock);
        chk("b2b.gapbusy", {31'h0, busy}, 32'h0);
        chk("b2b.gapreq",  {31'h0, mem_req}, 32'h0);
        addr = 32'h0000_7000; data = 32'h0000_0002;
        @(negedge clock);
        chk_beat("b2b.second", 32'h0000_7000, 32'h0000_0002, 4'b1111);
        @(negedge clock);
        chk("b2b.done2", {31'h0, done}, 32'h1);
        start = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        chk("b2b.endbusy", {31'h0, busy}, 32'h0);
        chk("b2b.endreq",  {31'h0, mem_req}, 32'h0);

        // reset while a store is in flight, colliding with start and mem_ack
        @(negedge clock);
`ifdef STORE_ALIGNER_SPLIT_EN
        start = 1'b1; mem_ack = 1'b1; ir = mk_ir(3'b010); addr = 32'h0000_3001; data = 32'h1122_3344;
        @(negedge clock);
        start = 1'b0; mem_ack = 1'b0;
        chk_beat("abort.b1", 32'h0000_3000, 32'h2233_4400, 4'b1110);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk_beat("abort.b2", 32'h0000_3004, 32'h0000_0011, 4'b0001);
`else
        start = 1'b1; mem_ack = 1'b0; ir = mk_ir(3'b001); addr = 32'h0000_2002; data = 32'h0000_BEEF;
        @(negedge clock);
        chk_beat("abort.b1", 32'h0000_2000, 32'hBEEF_0000, 4'b1100);
`endif
        reset = 1'b0; start = 1'b1; mem_ack = 1'b1;
        @(negedge clock);
        chk_all_zero("abort");
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("abort.nodone", {31'h0, done}, 32'h0);
            chk("abort.nobusy", {31'h0, busy}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_aligner.md
STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  store request; sampled only in IDLE.
- ir  in  32  instruction register; ir[14:12] gives the store type: 000 SB, 001 SH, 010 SW.
- addr  in  32  byte address of the store.
- data  in  32  register data to store; the LSB-aligned byte, half or word is used.
- mem_addr  out  32  word-aligned bus address; [1:0] always 00.
- mem_wrdata  out  32  lane-aligned write data.
- mem_wrbits  out  4  byte-lane write enables; bit i enables byte lane i.
- mem_req  out  1  bus request.
- mem_ack  in  1  bus acknowledge; accepts the current beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse; asserts together with done.

Function
REQ-002 The FSM SHALL have the states IDLE, REQ1, REQ2, FIN.
REQ-003 In IDLE with start=1, the block SHALL capture ir[14:12], addr and data, then enter REQ1, or enter FIN with error on the next edge.
REQ-004 The offset SHALL be off=addr[1:0]; the base mask SHALL be 0001 for SB, 0011 for SH, 1111 for SW.
REQ-005 The beat-1 values SHALL be:
- mem_addr = {addr[31:2],2'b00}
- mem_wrdata = data << (8*off), truncated to 32 bits
- mem_wrbits = low 4 bits of (mask << off)
REQ-006 A store SHALL be misaligned when (mask << off) has any bit set above bit 3: SH at off=3, or SW at off≠0.
REQ-007 The beat-2 values SHALL be:
- mem_addr = beat-1 address + 4, wrapping modulo 2^32
- mem_wrdata = data >> (8*(4-off))
- mem_wrbits = bits [7:4] of (mask << off)
REQ-008 mem_req SHALL be 1 exactly in REQ1 and REQ2; mem_addr, mem_wrdata and mem_wrbits SHALL be stable while mem_req=1 and mem_ack=0.
REQ-009 A beat SHALL complete on an edge where mem_req=1 and mem_ack=1; mem_ack SHALL be ignored while mem_req=0.
REQ-010 On completion in REQ1 the FSM SHALL go to REQ2 when the store needs a second beat, otherwise to FIN; on completion in REQ2 it SHALL go to FIN.
REQ-011 In FIN, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 An ir[14:12] value other than 000, 001 or 010 SHALL take IDLE to FIN with err=1 and no bus beat.
REQ-013 start SHALL be ignored while busy=1; the earliest next capture SHALL be the cycle after done.
REQ-014 Minimum latency SHALL be: start edge -> mem_req next cycle; mem_ack in the same cycle -> done the following cycle, i.e. 3 cycles from start to done for one beat and 4 for two beats.
REQ-015 Outside REQ1/REQ2, mem_wrbits SHALL be 0000 and mem_wrdata SHALL be 0.

Reset
REQ-016 With reset=0 at a rising edge, the FSM SHALL go to IDLE and mem_req, mem_wrbits, mem_wrdata, mem_addr, busy, done and err SHALL all be 0.
REQ-017 Reset SHALL abort an in-flight store in any state, including mid-REQ2; no done pulse SHALL follow.
REQ-018 Reset SHALL take priority over start and mem_ack on the same edge.

Configuration
REQ-019 The macro STORE_ALIGNER_SPLIT_EN SHALL control handling of misaligned stores:
- Defined: a misaligned store executes as two beats (REQ1 then REQ2), then done with err=0.
- Undefined: a misaligned store goes IDLE -> FIN with done=1, err=1 and no bus beat; REQ2 is unreachable.
- Either way, aligned behaviour SHALL be identical.

Verification
REQ-020 SB, addr=0x00001002, data=0x000000A5, mem_ack held 1 -> mem_addr=0x00001000, mem_wrbits=0100, mem_wrdata=0x00A50000; done 3 cycles after start; err=0.
REQ-021 SH, addr=0x00002002, data=0x0000BEEF, mem_ack delayed 3 cycles -> mem_wrbits=1100, mem_wrdata=0xBEEF0000, outputs held stable until ack; then done.
REQ-022 SW, addr=0x00003001, data=0x11223344 with SPLIT_EN defined:
- beat 1 -> mem_addr=0x00003000, mem_wrbits=1110, mem_wrdata=0x22334400
- beat 2 -> mem_addr=0x00003004, mem_wrbits=0001, mem_wrdata=0x00000011
- done with err=0
REQ-023 The same stimulus as REQ-022 with SPLIT_EN undefined -> no mem_req, done=1 and err=1 two cycles after start; ir[14:12]=011 -> same response.
REQ-024 SH at addr=0xFFFFFFFF with SPLIT_EN defined -> beat-2 mem_addr wraps to 0x00000000; asserting reset=0 during REQ2 -> next cycle all outputs 0, no done pulse.
REQ-025 start held 1 continuously across two back-to-back aligned SW stores -> second capture on the cycle after done; start during busy causes no extra beat.
